// File: rtl/cmd_frame_sched.sv
// cmd_frame_sched: read-side scheduler for the 40-to-160 command FIFO.
// Fetches command words into a one-entry holding buffer and emits one
// frame (SYNC, CMD or IDLE) every FRAME_CYC cycles of clk160.
module cmd_frame_sched #(
    parameter int unsigned FRAME_CYC   = 4,
    parameter int unsigned SYNC_PERIOD = 32,
    parameter logic [15:0] SYNC_WORD   = 16'h817E,
    parameter logic [15:0] IDLE_WORD   = 16'hAAAA
) (
    input  logic        clk160,
    input  logic        rst,
    input  logic        en,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        rd_cmd,
    output logic        frame_strobe,
    output logic [15:0] frame_data,
    output logic [1:0]  frame_type,
    output logic [15:0] cmd_cnt
);

    localparam int unsigned PH_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int unsigned SY_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_CYC - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(SYNC_PERIOD - 1);

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_CMD  = 2'b01;
    localparam logic [1:0] T_SYNC = 2'b10;

    typedef enum logic {F_IDLE, F_WAIT} fetch_e;

    fetch_e          fetch_q, fetch_d;
    logic            buf_full_q, buf_full_d;
    logic [15:0]     buf_data_q, buf_data_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [SY_W-1:0] sync_ctr_q, sync_ctr_d;
    logic            strobe_q, strobe_d;
    logic [15:0]     fdata_q, fdata_d;
    logic [1:0]      ftype_q, ftype_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            rd_req;

    // Request a word only when idle, enabled and the holding buffer is empty.
    always_comb begin
        rd_req = (fetch_q == F_IDLE) && en && !buf_full_q;
    end

    // The FIFO must never see a read pulse while reset is held.
    assign rd_cmd       = rd_req && rst;
    assign frame_strobe = strobe_q;
    assign frame_data   = fdata_q;
    assign frame_type   = ftype_q;
    assign cmd_cnt      = cnt_q;

    // Next-state: fetch handshake, frame phase and slot selection.
    always_comb begin
        fetch_d    = fetch_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        phase_d    = phase_q;
        sync_ctr_d = sync_ctr_q;
        strobe_d   = 1'b0;
        fdata_d    = fdata_q;
        ftype_d    = ftype_q;
        cnt_d      = cnt_q;

        // A pending read always completes, even if en has dropped meanwhile;
        // a low valid means the FIFO was empty and the next cycle retries.
        case (fetch_q)
            F_IDLE: begin
                if (rd_req) begin
                    fetch_d = F_WAIT;
                end
            end
            F_WAIT: begin
                fetch_d = F_IDLE;
                if (cmd_valid) begin
                    buf_full_d = 1'b1;
                    buf_data_d = cmd_data;
                end
            end
            default: fetch_d = F_IDLE;
        endcase

        if (!en) begin
            phase_d    = '0;
            sync_ctr_d = '0;
        end else begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (phase_q == PH_LAST) begin
                strobe_d = 1'b1;
                if (sync_ctr_q == SY_LAST) begin
                    // Sync wins the slot; a buffered command waits.
                    fdata_d    = SYNC_WORD;
                    ftype_d    = T_SYNC;
                    sync_ctr_d = '0;
                end else if (buf_full_q) begin
                    fdata_d    = buf_data_q;
                    ftype_d    = T_CMD;
                    buf_full_d = 1'b0;
                    cnt_d      = cnt_q + 16'd1;
                    sync_ctr_d = sync_ctr_q + 1'b1;
                end else begin
                    fdata_d    = IDLE_WORD;
                    ftype_d    = T_IDLE;
                    sync_ctr_d = sync_ctr_q + 1'b1;
                end
            end
        end
    end

    // Control state and registered frame outputs.
    always_ff @(posedge clk160 or negedge rst) begin
        if (!rst) begin
            fetch_q    <= F_IDLE;
            buf_full_q <= 1'b0;
            phase_q    <= '0;
            sync_ctr_q <= '0;
            strobe_q   <= 1'b0;
            fdata_q    <= IDLE_WORD;
            ftype_q    <= T_IDLE;
            cnt_q      <= '0;
        end else begin
            fetch_q    <= fetch_d;
            buf_full_q <= buf_full_d;
            phase_q    <= phase_d;
            sync_ctr_q <= sync_ctr_d;
            strobe_q   <= strobe_d;
            fdata_q    <= fdata_d;
            ftype_q    <= ftype_d;
            cnt_q      <= cnt_d;
        end
    end

    // Holding buffer payload; meaningful only while buf_full_q is set.
    always_ff @(posedge clk160) begin
        buf_data_q <= buf_data_d;
    end

endmodule

// File: doc/cmd_frame_sched.md
Name: cmd_frame_sched

Overview:
- Read-side scheduler for the 40-to-160 command word FIFO, running entirely in the clk160 domain.
- Pulls 16-bit command words from the FIFO using a rd_en/valid handshake and keeps them in a single-entry holding buffer.
- Emits one 16-bit output frame every FRAME_CYC clocks: a SYNC word when the sync interval expires, otherwise a buffered command, otherwise an IDLE word.
- Sits between the FIFO read port and the downstream serializer.

Parameters:
- FRAME_CYC, 4: clk160 cycles per output frame (2..16).
- SYNC_PERIOD, 32: frames per sync interval; one SYNC frame is sent per interval (2..256).
- SYNC_WORD, 16'h817E: frame content for sync slots.
- IDLE_WORD, 16'hAAAA: frame content when no command is buffered.

Ports:
- clk160  in  1  scheduler clock; all logic is on this clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scheduler enable (level).
- cmd_valid  in  1  FIFO valid; high in the cycle after an accepted rd_cmd.
- cmd_data  in  16  FIFO read data; qualified by cmd_valid.
- rd_cmd  out  1  FIFO read enable, single-cycle pulse.
- frame_strobe  out  1  one-cycle pulse; frame_data/frame_type are new this cycle.
- frame_data  out  16  current frame word.
- frame_type  out  2  00 = IDLE, 01 = CMD, 10 = SYNC.
- cmd_cnt  out  16  count of CMD frames sent; wraps.

Behaviour:
- Reset values (asynchronous, active-low rst):
  - rd_cmd = 0, frame_strobe = 0, frame_data = IDLE_WORD, frame_type = 00, cmd_cnt = 0.
  - Holding buffer empty, phase = 0, sync_ctr = 0, fetch FSM in F_IDLE.
- Fetch FSM states: F_IDLE and F_WAIT.
  - F_IDLE: if en=1 and the holding buffer is empty, assert rd_cmd for this cycle and go to F_WAIT. Otherwise stay in F_IDLE with rd_cmd = 0.
  - F_WAIT: rd_cmd = 0. If cmd_valid=1, load cmd_data into the holding buffer and mark it full. Always return to F_IDLE.
  - A valid-low return in F_WAIT means the FIFO was empty: no load occurs, and a retry is issued in the following cycle.
  - rd_cmd is therefore high in at most one of any two consecutive cycles.
  - cmd_valid seen while in F_IDLE is ignored.
- Frame timing:
  - phase counts 0..FRAME_CYC-1 while en=1 and wraps.
  - The slot decision is made in the cycle where phase = FRAME_CYC-1. frame_strobe, frame_data, frame_type and cmd_cnt update on the clock edge that ends that cycle.
  - After en rises with phase = 0, the first strobe appears FRAME_CYC cycles later; after that, exactly one strobe per FRAME_CYC cycles.
- Slot selection, in priority order:
  1. If sync_ctr = SYNC_PERIOD-1: send SYNC and set sync_ctr = 0. Any buffered command is kept for a later slot.
  2. Else, if the holding buffer is full: send CMD with the buffered word, empty the buffer, increment cmd_cnt (wraps at 16'hFFFF to 0), and increment sync_ctr.
  3. Else: send IDLE and increment sync_ctr.
- Simultaneous events: a buffer load (F_WAIT) only happens while the buffer is empty, and consumption only happens while it is full, so the two can never coincide.
  - If a load and an IDLE decision fall in the same cycle, the IDLE frame is sent and the loaded word goes in the next slot.
- Ordering: commands leave in FIFO order; none are dropped or duplicated.
- en deassertion:
  - phase and sync_ctr reset to 0; frame_strobe = 0; frame_data/frame_type hold their last values.
  - The FSM issues no new rd_cmd, but an F_WAIT in progress completes and may load the buffer.
  - The buffer contents are kept and are sent in the first non-SYNC slot after re-enable.
- rst asserted mid-operation: all state returns to reset values immediately. A buffered word is discarded.

Test Plan:
- Reset with en=0, FIFO empty -> rd_cmd=0, frame_strobe never asserts, frame_data=16'hAAAA, cmd_cnt=0.
- en=1, FIFO never returns valid, defaults -> strobe every 4 cycles. Frames 0..30 are IDLE (type 00), frame 31 is SYNC 16'h817E (type 10), then the pattern repeats. rd_cmd toggles 1,0,1,0,...
- FIFO preloaded with 16'h0001..16'h0028 (40 words) -> frames 0..30 carry 0001..001F, frame 31 is SYNC, frames 32..40 carry 0020..0028, then IDLE. cmd_cnt=40 at the end.
- Valid arrives in the same cycle the slot at frame 31 is decided -> SYNC is sent first, the word appears in frame 32, and cmd_cnt increments only at frame 32.
- en dropped while a word is buffered (value 16'hBEEF), held low 20 cycles, then raised -> no strobes while low; the first frame after re-enable is CMD 16'hBEEF.
- cmd_cnt preset near wrap by sending 65537 commands -> cmd_cnt reads 1. rst pulsed mid-frame -> all outputs return to reset values asynchronously.
